// File: rtl/branch_fb_gen_pkg.sv
// core: shared core types and widths used by the branch feedback path
package core;

    typedef logic bool_t;

    localparam int peval_width = 4;
    localparam int pc_width    = 32;

    typedef struct packed {
        bool_t                valid;
        logic [pc_width-1:0]  base_pc;
        bool_t                branch_taken;
    } branch_pred_fb_t;

    typedef struct packed {
        bool_t                valid;
        logic [pc_width-1:0]  base_pc;
        bool_t                branch_taken;
        bool_t                pred_taken;
    } branch_res_t;

endpackage

// File: rtl/branch_fb_gen_if.sv
// branch_fb_gen_if: resolve lanes in, predictor feedback and statistics out
interface branch_fb_gen_if
    import core::*;
#(
    parameter int stat_width = 32
);
    bool_t                          en;
    bool_t                          flush;
    branch_res_t [peval_width-1:0]  res;
    bool_t                          rdy;
    branch_pred_fb_t                fb;
    logic [stat_width-1:0]          br_cnt;
    logic [stat_width-1:0]          mispred_cnt;

    modport master (output en, flush, res, input rdy, fb, br_cnt, mispred_cnt);
    modport slave  (input en, flush, res, output rdy, fb, br_cnt, mispred_cnt);
endinterface

// File: rtl/branch_fb_gen_mpush_fifo.sv
// mpush_fifo: circular buffer taking up to w compacted entries per cycle and releasing one
module mpush_fifo #(
    parameter int w     = 4,
    parameter int depth = 8,
    parameter int dw    = 34,
    localparam int aw   = $clog2(depth),
    localparam int cw   = $clog2(depth + 1),
    localparam int pw   = $clog2(w + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] push_data_i [w],
    input  logic [pw-1:0] push_cnt_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [dw-1:0] head_o,
    output logic [cw-1:0] count_o
);
    logic [dw-1:0] mem_q [depth];
    logic [aw-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [cw-1:0] cnt_q, cnt_d;

    // pointer and occupancy update; flush returns everything to empty
    always_comb begin
        rd_d  = flush_i ? '0 : rd_q + aw'(pop_i);
        wr_d  = flush_i ? '0 : wr_q + aw'(push_cnt_i);
        cnt_d = flush_i ? '0 : cnt_q + cw'(push_cnt_i) - cw'(pop_i);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // write the first push_cnt_i compacted entries at consecutive slots
    always_ff @(posedge clk) begin
        if (!flush_i)
            for (int i = 0; i < w; i++)
                if (i < int'(push_cnt_i))
                    mem_q[wr_q + aw'(i)] <= push_data_i[i];
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/branch_fb_gen.sv
// branch_fb_gen: serializes per-lane branch resolves onto the predictor feedback port; BRANCH_FB_STATS_EN adds branch/mispredict counters
module branch_fb_gen
    import core::*;
#(
    parameter int fifo_depth = 8,
    parameter int stat_width = 32
) (
    input logic            clk,
    input logic            rst,
    branch_fb_gen_if.slave bus
);
    localparam int cw = $clog2(fifo_depth + 1);
    localparam int pw = $clog2(peval_width + 1);
    localparam int lw = peval_width > 1 ? $clog2(peval_width) : 1;
`ifdef BRANCH_FB_STATS_EN
    localparam int dw = pc_width + 2;
`else
    localparam int dw = pc_width + 1;
`endif

    logic [dw-1:0] push_data [peval_width];
    logic [pw-1:0] n_valid;
    logic [dw-1:0] head;
    logic [cw-1:0] count;
    logic          push, pop;

    assign bus.rdy = count <= cw'(fifo_depth - peval_width);
    assign push    = bus.en && bus.rdy && !bus.flush;
    assign pop     = bus.en && count != '0 && !bus.flush && !rst;

    // compact valid lanes in lane order; entry is {pred_taken, base_pc, taken}, top bit dropped without stats
    always_comb begin
        n_valid = '0;
        for (int i = 0; i < peval_width; i++)
            push_data[i] = '0;
        for (int i = 0; i < peval_width; i++)
            if (bus.res[i].valid) begin
                push_data[lw'(n_valid)] = dw'({bus.res[i].pred_taken, bus.res[i].base_pc, bus.res[i].branch_taken});
                n_valid = n_valid + pw'(1);
            end
    end

    mpush_fifo #(
        .w     (peval_width),
        .depth (fifo_depth),
        .dw    (dw)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_data_i (push_data),
        .push_cnt_i  (push ? n_valid : '0),
        .pop_i       (pop),
        .flush_i     (bus.flush),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.fb = count != '0 ? {1'b1, head[pc_width:1], head[0]} : '0;

`ifdef BRANCH_FB_STATS_EN
    logic [stat_width-1:0] br_q, br_d, mis_q, mis_d;

    // saturating counters that already include the pop happening this cycle
    always_comb begin
        br_d  = pop && !(&br_q) ? br_q + 1'b1 : br_q;
        mis_d = pop && head[dw-1] != head[0] && !(&mis_q) ? mis_q + 1'b1 : mis_q;
    end

    // counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign bus.br_cnt      = br_d;
    assign bus.mispred_cnt = mis_d;
`else
    assign bus.br_cnt      = '0;
    assign bus.mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_fb_gen.sv
// tb_branch_fb_gen: directed table-driven bench for branch_fb_gen
module tb_branch_fb_gen;
    import core::*;

`ifdef BRANCH_FB_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    typedef struct {
        logic        en, fl;
        logic [3:0]  v;
        logic [31:0] pcs;
        logic [3:0]  tk, pt;
        logic        ev;
        logic [7:0]  epc;
        logic        etk, erdy;
        int          ebr, emis;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    branch_fb_gen_if #(.stat_width(32)) bus ();

    branch_fb_gen #(.fifo_depth(8), .stat_width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic vec_t mk(logic en, logic fl, logic [3:0] v, logic [31:0] pcs,
                                logic [3:0] tk, logic [3:0] pt, logic ev, logic [7:0] epc,
                                logic etk, logic erdy, int ebr, int emis);
        vec_t r;
        r.en = en; r.fl = fl; r.v = v; r.pcs = pcs; r.tk = tk; r.pt = pt;
        r.ev = ev; r.epc = epc; r.etk = etk; r.erdy = erdy;
        r.ebr = ebr * S; r.emis = emis * S;
        return r;
    endfunction

    function automatic vec_t idle(logic ev, logic [7:0] epc, logic etk, logic erdy, int ebr, int emis);
        return mk(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 4'h0, ev, epc, etk, erdy, ebr, emis);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t r);
        bus.en = r.en;
        bus.flush = r.fl;
        for (int i = 0; i < 4; i++) begin
            bus.res[i].valid        = r.v[i];
            bus.res[i].base_pc      = {24'h0, r.pcs[i*8 +: 8]};
            bus.res[i].branch_taken = r.tk[i];
            bus.res[i].pred_taken   = r.pt[i];
        end
    endtask

    task automatic check_out(string tag, logic ev, logic [31:0] epc, logic etk, logic erdy, int ebr, int emis);
        chk({tag, ".fb.valid"}, 32'(bus.fb.valid), 32'(ev));
        chk({tag, ".fb.base_pc"}, bus.fb.base_pc, epc);
        chk({tag, ".fb.taken"}, 32'(bus.fb.branch_taken), 32'(etk));
        chk({tag, ".rdy"}, 32'(bus.rdy), 32'(erdy));
        chk({tag, ".br_cnt"}, bus.br_cnt, 32'(ebr));
        chk({tag, ".mispred_cnt"}, bus.mispred_cnt, 32'(emis));
    endtask

    initial begin
        // single resolve, lane 1
        vecs.push_back(idle(0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4'b0010, 32'h00004000, 4'b0010, 4'b0000, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(idle(1, 8'h40, 1, 1, 1, 1));
        vecs.push_back(idle(0, 8'h00, 0, 1, 1, 1));
        // compaction and ordering across cycles
        vecs.push_back(mk(1, 0, 4'b0101, 32'h00200010, 4'b0100, 4'b0100, 0, 8'h00, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 4'b0001, 32'h00000030, 4'b0000, 4'b0001, 1, 8'h10, 0, 1, 2, 1));
        vecs.push_back(idle(1, 8'h20, 1, 1, 3, 1));
        vecs.push_back(idle(1, 8'h30, 0, 1, 4, 2));
        vecs.push_back(idle(0, 8'h00, 0, 1, 4, 2));
        // enable low with 3 buffered
        vecs.push_back(mk(1, 0, 4'b0111, 32'h00525150, 4'b0111, 4'b0111, 0, 8'h00, 0, 1, 4, 2));
        vecs.push_back(mk(0, 0, 4'b0001, 32'h00000060, 4'b0001, 4'b0000, 1, 8'h50, 1, 1, 4, 2));
        vecs.push_back(mk(0, 0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 1, 8'h50, 1, 1, 4, 2));
        vecs.push_back(idle(1, 8'h50, 1, 1, 5, 2));
        vecs.push_back(idle(1, 8'h51, 1, 1, 6, 2));
        vecs.push_back(idle(1, 8'h52, 1, 1, 7, 2));
        vecs.push_back(idle(0, 8'h00, 0, 1, 7, 2));
        // full buffer and back-pressure, upstream holding while rdy low
        vecs.push_back(mk(1, 0, 4'hf, 32'h73727170, 4'h0, 4'hf, 0, 8'h00, 0, 1, 7, 2));
        vecs.push_back(mk(1, 0, 4'hf, 32'h77767574, 4'h0, 4'hf, 1, 8'h70, 0, 1, 8, 3));
        vecs.push_back(mk(1, 0, 4'hf, 32'h7b7a7978, 4'h0, 4'hf, 1, 8'h71, 0, 0, 9, 4));
        vecs.push_back(mk(1, 0, 4'hf, 32'h7b7a7978, 4'h0, 4'hf, 1, 8'h72, 0, 0, 10, 5));
        vecs.push_back(mk(1, 0, 4'hf, 32'h7b7a7978, 4'h0, 4'hf, 1, 8'h73, 0, 0, 11, 6));
        vecs.push_back(mk(1, 0, 4'hf, 32'h7b7a7978, 4'h0, 4'hf, 1, 8'h74, 0, 1, 12, 7));
        vecs.push_back(idle(1, 8'h75, 0, 0, 13, 8));
        vecs.push_back(idle(1, 8'h76, 0, 0, 14, 9));
        vecs.push_back(idle(1, 8'h77, 0, 0, 15, 10));
        vecs.push_back(idle(1, 8'h78, 0, 1, 16, 11));
        vecs.push_back(idle(1, 8'h79, 0, 1, 17, 12));
        vecs.push_back(idle(1, 8'h7a, 0, 1, 18, 13));
        vecs.push_back(idle(1, 8'h7b, 0, 1, 19, 14));
        vecs.push_back(idle(0, 8'h00, 0, 1, 19, 14));
        // flush with 5 buffered and a push presented
        vecs.push_back(mk(1, 0, 4'hf, 32'h83828180, 4'hf, 4'h0, 0, 8'h00, 0, 1, 19, 14));
        vecs.push_back(mk(1, 0, 4'b0011, 32'h00008584, 4'b0011, 4'b0000, 1, 8'h80, 1, 1, 20, 15));
        vecs.push_back(mk(1, 1, 4'b0011, 32'h00009190, 4'b0011, 4'b0000, 1, 8'h81, 1, 0, 20, 15));
        vecs.push_back(idle(0, 8'h00, 0, 1, 20, 15));
        vecs.push_back(idle(0, 8'h00, 0, 1, 20, 15));
        // flush while ready drops the same-cycle resolve
        vecs.push_back(mk(1, 1, 4'b0001, 32'h000000a0, 4'b0001, 4'b0000, 0, 8'h00, 0, 1, 20, 15));
        vecs.push_back(idle(0, 8'h00, 0, 1, 20, 15));

        drive(idle(0, 8'h00, 0, 1, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_out("reset", 0, 32'h0, 0, 1, 0, 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k]);
            #1;
            check_out($sformatf("vec%0d", k), vecs[k].ev, {24'h0, vecs[k].epc}, vecs[k].etk,
                      vecs[k].erdy, vecs[k].ebr, vecs[k].emis);
        end

        // reset in the middle of operation discards buffered entries and counters
        @(negedge clk);
        drive(mk(1, 0, 4'b0011, 32'h0000b1b0, 4'b0011, 4'b0000, 0, 8'h00, 0, 1, 0, 0));
        @(negedge clk);
        drive(idle(0, 8'h00, 0, 1, 0, 0));
        #1;
        check_out("midop_pre", 1, 32'hb0, 1, 1, 21 * S, 16 * S);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_out("midop_reset", 0, 32'h0, 0, 1, 0, 0);
        @(negedge clk);
        #1;
        check_out("midop_after", 0, 32'h0, 0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_fb_gen.md
# branch_fb_gen

Producer side of the branch-prediction feedback interface. Collects resolved branches from the `core::peval_width` parallel evaluation lanes in one cycle. Buffers them in program order and serializes them onto the single `core::branch_pred_fb_t` port consumed by the branch predictor, at one entry per cycle. It sits between the evaluation/retire stage and the predictor, and exerts back-pressure on the lanes when its buffer cannot absorb a full cycle of resolves.

## Interface
- `fifo_depth`, default 8: buffer entries. Must be a power of two and ≥ `core::peval_width`.
- `stat_width`, default 32: width of the statistics counters. Only meaningful with `BRANCH_FB_STATS_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  bool_t  synchronous, active-high reset.
- `en`  in  bool_t  global enable. When low, state is frozen: no push, no pop.
- `flush`  in  bool_t  discard all buffered entries.
- `res`  in  core::branch_res_t [core::peval_width]  per-lane resolve with fields `valid`, `base_pc`, `branch_taken`, `pred_taken`. Lane 0 is oldest.
- `rdy`  out  bool_t  buffer can accept a full cycle of resolves.
- `fb`  out  core::branch_pred_fb_t  feedback to predictor with fields `valid`, `base_pc`, `branch_taken`.
- `br_cnt`  out  stat_width  branches emitted on `fb`.
- `mispred_cnt`  out  stat_width  emitted branches with `branch_taken != pred_taken`.

## Operation
- **Storage**: circular buffer with `fifo_depth` entries.
  - `rd_ptr` and `wr_ptr` are `$clog2(fifo_depth)` bits wide and wrap modulo `fifo_depth`.
  - `count` is `$clog2(fifo_depth+1)` bits wide.
- **Ready**: `rdy = (count <= fifo_depth - peval_width)`, computed combinationally from registered `count`.
- **Push**: occurs when `en && rdy && !flush`.
  - Valid lanes are compacted in ascending lane order and written at `wr_ptr`, `wr_ptr+1`, and so on.
  - `wr_ptr` and `count` advance by the number of valid lanes (popcount of valid).
  - Invalid lanes between valid ones leave no holes.
- **Push while not ready**: lane valids presented while `rdy` is low are ignored. Upstream must hold them.
- **Pop**: occurs when `en && count != 0 && !flush`.
  - `fb` is driven from the entry at `rd_ptr`.
  - `rd_ptr` increments and `count` decrements.
- **Output when idle**: when `count == 0`, `fb.valid = 0` and the `fb` payload fields are 0.
- **Simultaneous push and pop**: allowed in the same cycle. `count_next = count + pushed - popped`.
- **Flush**: has priority over push and pop. The next cycle has `rd_ptr = wr_ptr = count = 0`, and the same-cycle `res` is dropped.
- **Reset**: pointers, `count`, and counters are cleared to 0.
  - Outputs after reset: `fb.valid = 0`, `rdy = 1`, `br_cnt = 0`, `mispred_cnt = 0`.
  - Reset mid-operation discards all buffered entries.

## Timing
- **Latency**: a resolve pushed in cycle N can appear on `fb` in cycle N+1 at the earliest, when the buffer was empty. `fb` is driven combinationally from buffer storage, and the storage is registered.
- **Throughput**: one `fb` entry per cycle while `count > 0` and `en` is high. The predictor is always ready and there is no `fb` handshake.
- **Ordering**: entries are emitted in strict program order: older cycles first, then lane index within a cycle.
- **`rdy` timing**: `rdy` changes only on clock edges, one cycle after `count` changes.
- **Counters**: counters update in the same cycle as the pop of the counted entry and saturate at all-ones.

## Configuration
- **`BRANCH_FB_STATS_EN` defined**:
  - `br_cnt` increments on every pop.
  - `mispred_cnt` increments on every pop whose `branch_taken != pred_taken`.
  - Flush and reset clear neither counter's saturation rules, but reset zeroes both counters.
- **`BRANCH_FB_STATS_EN` undefined**:
  - No counter registers are built.
  - `br_cnt` and `mispred_cnt` are tied to 0.
  - `pred_taken` is not stored in the buffer.
  - The port list is unchanged.

## Structure
- **Shared package `core`**:
  - New typedef `branch_res_t`, a struct with fields `valid`, `base_pc`, `branch_taken`, `pred_taken`.
  - Existing `branch_pred_fb_t` and `peval_width` are reused unchanged.
- **Sub-module `mpush_fifo`**: one natural sub-module, a multi-push single-pop FIFO.
  - Parameters: push width and depth.
  - Ports: compacted push vector, push count, pop, flush, head, count.
  - Lane compaction and statistics stay in `branch_fb_gen`.

## Test plan
- **Reset**: assert `rst` for 2 cycles → `fb.valid = 0`, `rdy = 1`, counters = 0.
- **Single resolve**: lane 1 only, `base_pc = 0x40`, `taken = 1`, `pred_taken = 0`, cycle N → cycle N+1 shows `fb` = {1, 0x40, 1}, `mispred_cnt = 1`, `br_cnt = 1`. Cycle N+2 shows `fb.valid = 0`.
- **Compaction and order**: cycle N lanes {0: pc 0x10, 1: invalid, 2: pc 0x20}; cycle N+1 lane 0 pc 0x30 → `fb` emits 0x10, 0x20, 0x30 on consecutive cycles N+1 to N+3.
- **Full and back-pressure**: depth 8, width 4, all lanes valid for 3 cycles with the predictor draining → `rdy` drops once `count > 4`. Held inputs are not duplicated or lost, and all 12 PCs are emitted in order.
- **Flush**: 5 entries buffered, plus a flush in the same cycle as a push of 2 → the next cycle has `fb.valid = 0` and `count = 0`, and the pushed entries never appear.
- **Enable low**: `en = 0` with 3 entries buffered and a valid resolve presented → `fb` holds its head value, `count` stays 3, the resolve is dropped, and counters are unchanged.
